// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer.
package store_buffer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } sb_state_e;

    localparam int DEPTH_DEFAULT = 4;
    localparam int WADDR_W       = 30;
    localparam int DATA_W        = 32;
    // Entry layout: {word address, data}
    localparam int ENTRY_W       = WADDR_W + DATA_W;

endpackage

// File: rtl/store_fwd_match.sv
// Load-to-store forwarding lookup: finds the youngest valid buffered store
// whose word address matches the load.
module store_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ENTRY_W-1:0] entries,
    input  logic [DEPTH-1:0]              valid,
    input  logic [PTR_W-1:0]              tail,
    input  logic [WADDR_W-1:0]            load_addr,
    output logic                          hit,
    output logic [DATA_W-1:0]             data
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int o = DEPTH; o >= 1; o--) begin
            idx = tail - PTR_W'(o);
            if (valid[idx] && (entries[idx][ENTRY_W-1 -: WADDR_W] == load_addr)) begin
                hit  = 1'b1;
                data = entries[idx][DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between EXE/MEM and the memory stage.
// Define STORE_FWD_EN to enable store-to-load forwarding and loads bypassing queued stores.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_W_ENIn,
    input  logic        MEM_R_ENIn,
    input  logic [31:0] ALU_ResIn,
    input  logic [31:0] Value_RmIn,
    input  logic        MEM_ReadyIn,
    input  logic [31:0] DataMemoryIn,
    output logic        MEM_W_ENOut,
    output logic        MEM_R_ENOut,
    output logic [31:0] ALU_ResOut,
    output logic [31:0] Value_RmOut,
    output logic [31:0] LoadDataOut,
    output logic        ForwardHitOut,
    output logic        FreezeOut
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ENTRY_W-1:0] entries;
    logic [PTR_W-1:0]              head, tail;
    logic [CNT_W-1:0]              count;
    sb_state_e                     state, state_nxt;

    logic              full, empty, pop, push;
    logic              ld_hit, drain_ok, rd_req;
    logic [DATA_W-1:0] fwd_data;
    logic [ENTRY_W-1:0] head_entry;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign pop        = (state == WRITE) && MEM_ReadyIn;
    // A full buffer still accepts a store on the edge that frees the head slot.
    assign push       = MEM_W_ENIn && (!full || pop);
    assign head_entry = entries[head];

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] off;
    logic             hit_raw;

    always_comb begin
        valid = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - head;
            valid[i] = ({1'b0, off} < count);
        end
    end

    store_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
        .entries   (entries),
        .valid     (valid),
        .tail      (tail),
        .load_addr (ALU_ResIn[31:2]),
        .hit       (hit_raw),
        .data      (fwd_data)
    );

    assign ld_hit   = MEM_R_ENIn && hit_raw;
    assign drain_ok = !MEM_R_ENIn;
    assign rd_req   = MEM_R_ENIn && !ld_hit && (state == IDLE);
`else
    // Without forwarding a load waits for the buffer to fully drain.
    assign ld_hit   = 1'b0;
    assign fwd_data = '0;
    assign drain_ok = 1'b1;
    assign rd_req   = MEM_R_ENIn && (state == IDLE) && empty;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if ((!empty || push) && drain_ok) state_nxt = WRITE;
            WRITE: if (MEM_ReadyIn)                  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        MEM_W_ENOut   = (state == WRITE);
        MEM_R_ENOut   = rd_req;
        ALU_ResOut    = ALU_ResIn;
        Value_RmOut   = Value_RmIn;
        if (state == WRITE) begin
            ALU_ResOut  = {head_entry[ENTRY_W-1 -: WADDR_W], 2'b00};
            Value_RmOut = head_entry[DATA_W-1:0];
        end
        LoadDataOut   = ld_hit ? fwd_data : (rd_req ? DataMemoryIn : '0);
        ForwardHitOut = ld_hit;
        FreezeOut     = (MEM_W_ENIn && full && !pop)
                      || (MEM_R_ENIn && !ld_hit && !(rd_req && MEM_ReadyIn));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; count alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= {ALU_ResIn[31:2], Value_RmIn};
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer; expectations follow STORE_FWD_EN when defined.
module tb_store_buffer;

    logic        clk, rst;
    logic        MEM_W_ENIn, MEM_R_ENIn, MEM_ReadyIn;
    logic [31:0] ALU_ResIn, Value_RmIn, DataMemoryIn;
    logic        MEM_W_ENOut, MEM_R_ENOut, ForwardHitOut, FreezeOut;
    logic [31:0] ALU_ResOut, Value_RmOut, LoadDataOut;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .MEM_W_ENIn(MEM_W_ENIn), .MEM_R_ENIn(MEM_R_ENIn),
        .ALU_ResIn(ALU_ResIn), .Value_RmIn(Value_RmIn),
        .MEM_ReadyIn(MEM_ReadyIn), .DataMemoryIn(DataMemoryIn),
        .MEM_W_ENOut(MEM_W_ENOut), .MEM_R_ENOut(MEM_R_ENOut),
        .ALU_ResOut(ALU_ResOut), .Value_RmOut(Value_RmOut),
        .LoadDataOut(LoadDataOut), .ForwardHitOut(ForwardHitOut),
        .FreezeOut(FreezeOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst) assert (!(MEM_W_ENIn && MEM_R_ENIn)) else $error("illegal simultaneous load and store");

    int n_vec = 0, n_err = 0, mem_lat = 0, wait_cnt = 0;
    logic [63:0] wr_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] phy_mem[logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] phy_rd(input logic [31:0] a);
        return phy_mem.exists(a) ? phy_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory-stage model: ready once a request has been presented mem_lat cycles.
    task automatic settle();
        #1;
        if (MEM_W_ENOut || MEM_R_ENOut) MEM_ReadyIn = (wait_cnt >= mem_lat);
        else                            MEM_ReadyIn = 1'b0;
        DataMemoryIn = MEM_R_ENOut ? phy_rd(ALU_ResOut) : 32'hBAD0_BAD0;
        #1;
    endtask

    task automatic tick();
        logic [63:0] e;
        logic [31:0] le;
        if (MEM_W_ENOut && MEM_ReadyIn) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
                e = wr_q.pop_front();
                chk("wr_addr", ALU_ResOut, e[63:32]);
                chk("wr_data", Value_RmOut, e[31:0]);
            end
            phy_mem[ALU_ResOut] = Value_RmOut;
        end
        if (MEM_R_ENIn && !FreezeOut) begin
            if (ld_q.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
            else begin
                le = ld_q.pop_front();
                chk("ld_data", LoadDataOut, le);
            end
        end
        if (MEM_W_ENIn && !FreezeOut) begin
            wr_q.push_back({ALU_ResIn, Value_RmIn});
            ref_mem[ALU_ResIn] = Value_RmIn;
        end
        if ((MEM_W_ENOut || MEM_R_ENOut) && !MEM_ReadyIn) wait_cnt++;
        else wait_cnt = 0;
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        MEM_W_ENIn = w; MEM_R_ENIn = r; ALU_ResIn = a; Value_RmIn = d;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) begin settle(); tick(); end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        logic fr, acc;
        acc = 1'b0;
        drive(1'b1, 1'b0, a, d);
        for (int i = 0; i < 100 && !acc; i++) begin
            settle(); fr = FreezeOut; tick();
            if (!fr) acc = 1'b1;
        end
        if (!acc) chk("store_timeout", 32'd0, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic load(input logic [31:0] a);
        logic fr, acc;
        acc = 1'b0;
        ld_q.push_back(ref_rd(a));
        drive(1'b0, 1'b1, a, 32'h0);
        for (int i = 0; i < 100 && !acc; i++) begin
            settle(); fr = FreezeOut; tick();
            if (!fr) acc = 1'b1;
        end
        if (!acc) chk("load_timeout", 32'd0, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wen"}, {31'd0, MEM_W_ENOut}, 32'd0);
        chk({tag, "_ren"}, {31'd0, MEM_R_ENOut}, 32'd0);
        chk({tag, "_addr"}, ALU_ResOut, 32'd0);
        chk({tag, "_wdata"}, Value_RmOut, 32'd0);
        chk({tag, "_ldata"}, LoadDataOut, 32'd0);
        chk({tag, "_hit"}, {31'd0, ForwardHitOut}, 32'd0);
        chk({tag, "_frz"}, {31'd0, FreezeOut}, 32'd0);
    endtask

    initial begin
        logic done, seen_wr;
        rst = 1'b1; MEM_ReadyIn = 1'b0; DataMemoryIn = 32'h0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        settle(); chk_zero("reset"); tick();
        rst = 1'b0;

        // Single store drains the next cycle, one cycle in WRITE.
        mem_lat = 0;
        drive(1'b1, 1'b0, 32'h100, 32'h1111_1111);
        settle(); chk("st1_frz", {31'd0, FreezeOut}, 32'd0); tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("st1_wen", {31'd0, MEM_W_ENOut}, 32'd1);
        chk("st1_addr", ALU_ResOut, 32'h100);
        chk("st1_data", Value_RmOut, 32'h1111_1111);
        tick();
        settle(); chk("st1_wen_drop", {31'd0, MEM_W_ENOut}, 32'd0); tick();

        // Two stores to one address, then a load to it.
        mem_lat = 1000;
        drive(1'b1, 1'b0, 32'h200, 32'hA); settle(); tick();
        drive(1'b1, 1'b0, 32'h200, 32'hB); settle();
        chk("st2_frz", {31'd0, FreezeOut}, 32'd0); tick();
        ld_q.push_back(ref_rd(32'h200));
        drive(1'b0, 1'b1, 32'h200, 32'h0);
`ifdef STORE_FWD_EN
        settle();
        chk("fwd_hit", {31'd0, ForwardHitOut}, 32'd1);
        chk("fwd_data", LoadDataOut, 32'hB);
        chk("fwd_ren", {31'd0, MEM_R_ENOut}, 32'd0);
        chk("fwd_frz", {31'd0, FreezeOut}, 32'd0);
        tick();
        mem_lat = 0;
        idle(6);
`else
        mem_lat = 0;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            settle();
            chk("nofwd_hit", {31'd0, ForwardHitOut}, 32'd0);
            if (FreezeOut) chk("nofwd_wait_ren", {31'd0, MEM_R_ENOut}, 32'd0);
            else begin
                chk("nofwd_ren", {31'd0, MEM_R_ENOut}, 32'd1);
                chk("nofwd_drained", 32'(wr_q.size()), 32'd0);
                done = 1'b1;
            end
            tick();
        end
        if (!done) chk("nofwd_timeout", 32'd0, 32'd1);
        idle(2);
`endif
        chk("t2_drained", 32'(wr_q.size()), 32'd0);

        // Fill four entries with memory stalled; the fifth store freezes.
        mem_lat = 1000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'h50 + 32'(i));
            settle(); chk("fill_frz", {31'd0, FreezeOut}, 32'd0); tick();
        end
        drive(1'b1, 1'b0, 32'h410, 32'h55);
        settle(); chk("full_frz0", {31'd0, FreezeOut}, 32'd1); tick();
        settle(); chk("full_frz1", {31'd0, FreezeOut}, 32'd1); tick();
        mem_lat = 0;
        settle(); chk("full_pop_accept", {31'd0, FreezeOut}, 32'd0); tick();
        mem_lat = 1000;
        drive(1'b1, 1'b0, 32'h414, 32'h56);
        settle(); chk("still_full", {31'd0, FreezeOut}, 32'd1); tick();
        mem_lat = 0;
        store(32'h414, 32'h56);
        idle(16);
        chk("t3_drained", 32'(wr_q.size()), 32'd0);

        // Load miss behind an in-flight write with 3-cycle memory latency.
        mem_lat = 3;
        drive(1'b1, 1'b0, 32'h500, 32'h77); settle(); tick();
        ld_q.push_back(ref_rd(32'h300));
        drive(1'b0, 1'b1, 32'h300, 32'h0);
        done = 1'b0; seen_wr = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            settle();
            if (!seen_wr) chk("miss_hold_ren", {31'd0, MEM_R_ENOut}, 32'd0);
            else          chk("miss_ren", {31'd0, MEM_R_ENOut}, 32'd1);
            if (MEM_W_ENOut && MEM_ReadyIn) seen_wr = 1'b1;
            if (!FreezeOut) begin
                chk("miss_ready", {31'd0, MEM_ReadyIn}, 32'd1);
                chk("miss_ldata", LoadDataOut, DataMemoryIn);
                done = 1'b1;
            end
            tick();
        end
        if (!done) chk("miss_timeout", 32'd0, 32'd1);
        chk("miss_write_first", {31'd0, seen_wr}, 32'd1);
        idle(2);

        // Reset in the middle of a drain discards everything.
        mem_lat = 1000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h600 + 32'(4 * i), 32'hC0 + 32'(i));
            settle(); tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1; settle(); tick();
        rst = 1'b0;
        wr_q.delete();
        for (int i = 0; i < 3; i++) ref_mem.delete(32'h600 + 32'(4 * i));
        settle(); chk_zero("rst_mid"); tick();
        mem_lat = 0;
        ld_q.push_back(ref_rd(32'h600));
        drive(1'b0, 1'b1, 32'h600, 32'h0);
        settle();
        chk("rst_ld_ren", {31'd0, MEM_R_ENOut}, 32'd1);
        chk("rst_ld_hit", {31'd0, ForwardHitOut}, 32'd0);
        chk("rst_ld_frz", {31'd0, FreezeOut}, 32'd0);
        tick();
        idle(1);

        // Random mix of loads and stores over a small address window.
        for (int i = 0; i < 200; i++) begin
            mem_lat = int'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: store(32'h700 + 32'(4 * $urandom_range(0, 7)), $urandom);
                1: load(32'h700 + 32'(4 * $urandom_range(0, 7)));
                default: idle(1);
            endcase
        end
        mem_lat = 0;
        idle(30);
        chk("end_wr_q", 32'(wr_q.size()), 32'd0);
        chk("end_ld_q", 32'(ld_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
